// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
// Module   : fifo_uart_tx_if
// Purpose  : Read-side handshake between a FIFO and the UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data;

    // master = transmitter pulling bytes, slave = FIFO supplying them
    modport master (input fifo_empty, input fifo_data, output fifo_read);
    modport slave  (output fifo_empty, output fifo_data, input fifo_read);
endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pulls bytes from a FIFO and sends them as 8N1-style UART frames;
//            define FIFO_UART_TX_PARITY_EN to add an even parity bit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          tx_en,
    fifo_uart_tx_if.master     fifo,
    output logic               tx,
    output logic               busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH) + 1;

    localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic [BAUD_W-1:0]  r_baud;
    logic [BAUD_W-1:0]  w_baud_next;
    logic [BIT_W-1:0]   r_bit;
    logic [BIT_W-1:0]   w_bit_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               w_baud_end;
    logic               w_fifo_read;
`ifdef FIFO_UART_TX_PARITY_EN
    logic               r_parity;
    logic               w_parity_next;
`endif

    // Gated by reset so no strobe can escape while reset is held
    assign w_fifo_read    = (r_state == S_IDLE) & tx_en & ~fifo.fifo_empty & reset;
    assign fifo.fifo_read = w_fifo_read;
    assign w_baud_end     = (r_baud == c_BAUD_LAST);
    assign busy           = (r_state != S_IDLE);
    assign tx             = r_tx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_tx     <= w_tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_baud_next   = r_baud;
        w_bit_next    = r_bit;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        w_tx_next     = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_fifo_read) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_shift_next  = fifo.fifo_data;
                w_baud_next   = '0;
                w_bit_next    = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                w_parity_next = ^fifo.fifo_data;
`endif
                w_state_next  = S_START;
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next  = r_baud + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit == c_BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next  = r_baud + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next  = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // The line level is registered from the upcoming state so tx tracks state exactly
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: w_tx_next = w_parity_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Directed self-checking bench for fifo_uart_tx (CLKS_PER_BIT=4, WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NSEG = 11;
`else
    localparam int NSEG = 10;
`endif
    localparam int FRAME = NSEG * C;
    localparam int LOGN  = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx_en = 1'b0;
    logic tx;
    logic busy;

    int n_pass  = 0;
    int n_total = 0;
    int ncyc    = 0;

    logic tx_log [0:LOGN-1];
    logic rd_log [0:LOGN-1];
    logic bz_log [0:LOGN-1];

    fifo_uart_tx_if #(.WIDTH(8)) fif ();

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .tx_en (tx_en),
        .fifo  (fif),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Per-cycle record, taken mid-cycle
    always @(negedge clk) begin
        if (ncyc < LOGN) begin
            tx_log[ncyc] = tx;
            rd_log[ncyc] = fif.fifo_read;
            bz_log[ncyc] = busy;
        end
        ncyc = ncyc + 1;
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int find_read(input int from, input int to);
        for (int i = from; i < to && i < LOGN; i++)
            if (rd_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_reads(input int from, input int to);
        int n;
        n = 0;
        for (int i = from; i < to && i < LOGN; i++)
            if (rd_log[i] !== 1'b0) n++;
        return n;
    endfunction

    function automatic logic [63:0] exp_frame(input logic [7:0] b);
        logic [63:0] f;
        f = '1;
        for (int i = 0; i < FRAME; i++) begin
            int seg;
            seg = i / C;
            if (seg == 0)      f[i] = 1'b0;
            else if (seg <= 8) f[i] = b[seg-1];
`ifdef FIFO_UART_TX_PARITY_EN
            else if (seg == 9) f[i] = ^b;
`endif
            else               f[i] = 1'b1;
        end
        return f;
    endfunction

    // Frame starts two cycles after the read strobe (IDLE, LOAD)
    function automatic logic [63:0] got_frame(input int k);
        logic [63:0] f;
        f = '1;
        for (int i = 0; i < FRAME; i++)
            if (k + 2 + i < LOGN) f[i] = tx_log[k + 2 + i];
        return f;
    endfunction

    task automatic test_reset();
        int s;
        reset = 1'b0; tx_en = 1'b1; fif.fifo_empty = 1'b0; fif.fifo_data = 8'hA5;
        s = ncyc;
        repeat (5) next_cyc();
        for (int i = s; i < s + 4; i++) begin
            n_total++;
            if (tx_log[i] !== 1'b1) $display("FAIL reset_tx cyc %0d: got %b expected 1", i, tx_log[i]);
            else n_pass++;
            n_total++;
            if (rd_log[i] !== 1'b0) $display("FAIL reset_read cyc %0d: got %b expected 0", i, rd_log[i]);
            else n_pass++;
            n_total++;
            if (bz_log[i] !== 1'b0) $display("FAIL reset_busy cyc %0d: got %b expected 0", i, bz_log[i]);
            else n_pass++;
        end
        fif.fifo_empty = 1'b1;
        reset = 1'b1;
        repeat (2) next_cyc();
    endtask

    task automatic test_frame(input logic [7:0] b);
        int s, k, n;
        fif.fifo_data = b; fif.fifo_empty = 1'b0; tx_en = 1'b1;
        s = ncyc;
        next_cyc();
        fif.fifo_empty = 1'b1;
        repeat (FRAME + 8) next_cyc();

        k = find_read(s, s + 4);
        n_total++;
        if (k !== s) $display("FAIL frame_%h_read_at: got %0d expected %0d", b, k, s);
        else n_pass++;
        if (k < 0) k = s;

        n = count_reads(s, s + FRAME + 6);
        n_total++;
        if (n !== 1) $display("FAIL frame_%h_read_count: got %0d expected 1", b, n);
        else n_pass++;

        n_total++;
        if (got_frame(k) !== exp_frame(b))
            $display("FAIL frame_%h_bits: got %h expected %h", b, got_frame(k), exp_frame(b));
        else n_pass++;

        n_total++;
        if (tx_log[k+1] !== 1'b1 || bz_log[k+1] !== 1'b1 || bz_log[k+2] !== 1'b1)
            $display("FAIL frame_%h_load: got tx=%b busy=%b,%b expected tx=1 busy=1,1",
                     b, tx_log[k+1], bz_log[k+1], bz_log[k+2]);
        else n_pass++;

        n_total++;
        if (tx_log[k+2+FRAME] !== 1'b1 || bz_log[k+2+FRAME] !== 1'b0 || bz_log[k+1+FRAME] !== 1'b1)
            $display("FAIL frame_%h_end: got tx=%b busy=%b last_busy=%b expected tx=1 busy=0 last_busy=1",
                     b, tx_log[k+2+FRAME], bz_log[k+2+FRAME], bz_log[k+1+FRAME]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s, k1, k2, n;
        s = ncyc;
        tx_en = 1'b1;
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            fif.fifo_data  = (c < 2) ? 8'h55 : 8'h0F;
            fif.fifo_empty = (c < FRAME + 3) ? 1'b0 : 1'b1;
            next_cyc();
        end
        k1 = find_read(s, s + 2);
        n_total++;
        if (k1 !== s) $display("FAIL b2b_first_read: got %0d expected %0d", k1, s);
        else n_pass++;
        if (k1 < 0) k1 = s;

        k2 = find_read(k1 + 1, s + 2 * FRAME + 10);
        n_total++;
        if (k2 - k1 !== FRAME + 2) $display("FAIL b2b_spacing: got %0d expected %0d", k2 - k1, FRAME + 2);
        else n_pass++;

        n = count_reads(s, s + 2 * FRAME + 10);
        n_total++;
        if (n !== 2) $display("FAIL b2b_read_count: got %0d expected 2", n);
        else n_pass++;

        n_total++;
        if (tx_log[k1+FRAME+2] !== 1'b1 || tx_log[k1+FRAME+3] !== 1'b1 || tx_log[k1+FRAME+4] !== 1'b0)
            $display("FAIL b2b_gap: got %b%b%b expected 110",
                     tx_log[k1+FRAME+2], tx_log[k1+FRAME+3], tx_log[k1+FRAME+4]);
        else n_pass++;

        n_total++;
        if (got_frame(k1) !== exp_frame(8'h55))
            $display("FAIL b2b_frame1: got %h expected %h", got_frame(k1), exp_frame(8'h55));
        else n_pass++;

        n_total++;
        if (got_frame(k1 + FRAME + 2) !== exp_frame(8'h0F))
            $display("FAIL b2b_frame2: got %h expected %h", got_frame(k1 + FRAME + 2), exp_frame(8'h0F));
        else n_pass++;
    endtask

    task automatic test_tx_en_drop();
        int s, k, n;
        s = ncyc;
        for (int c = 0; c < FRAME + 80; c++) begin
            tx_en          = (c < 10 || c >= 70) ? 1'b1 : 1'b0;
            fif.fifo_data  = (c < 2) ? 8'h3C : 8'hFF;
            fif.fifo_empty = (c < 71) ? 1'b0 : 1'b1;
            next_cyc();
        end
        n_total++;
        if (rd_log[s] !== 1'b1) $display("FAIL txen_first_read: got %b expected 1", rd_log[s]);
        else n_pass++;

        n_total++;
        if (got_frame(s) !== exp_frame(8'h3C))
            $display("FAIL txen_frame: got %h expected %h", got_frame(s), exp_frame(8'h3C));
        else n_pass++;

        n = count_reads(s + 1, s + 70);
        n_total++;
        if (n !== 0) $display("FAIL txen_held_off: got %0d reads expected 0", n);
        else n_pass++;

        k = find_read(s + 1, s + FRAME + 80);
        n_total++;
        if (k !== s + 70) $display("FAIL txen_resume: got %0d expected %0d", k, s + 70);
        else n_pass++;
        if (k < 0) k = s + 70;

        n_total++;
        if (got_frame(k) !== exp_frame(8'hFF))
            $display("FAIL txen_frame2: got %h expected %h", got_frame(k), exp_frame(8'hFF));
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int s, r, k, n;
        fif.fifo_data = 8'h5A; fif.fifo_empty = 1'b0; tx_en = 1'b1;
        s = ncyc;
        next_cyc();
        fif.fifo_empty = 1'b1;
        repeat (9) next_cyc();

        n_total++;
        if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy);
        else n_pass++;

        fif.fifo_empty = 1'b0;
        reset = 1'b0;
        #1;
        n_total++;
        if (tx !== 1'b1 || busy !== 1'b0 || fif.fifo_read !== 1'b0)
            $display("FAIL rstmid_async: got tx=%b busy=%b read=%b expected 1 0 0",
                     tx, busy, fif.fifo_read);
        else n_pass++;

        r = ncyc;
        repeat (3) next_cyc();
        n = count_reads(r, r + 3);
        n_total++;
        if (n !== 0) $display("FAIL rstmid_no_read: got %0d expected 0", n);
        else n_pass++;

        fif.fifo_data = 8'h81;
        reset = 1'b1;
        s = ncyc;
        next_cyc();
        fif.fifo_empty = 1'b1;
        repeat (FRAME + 6) next_cyc();

        k = find_read(s, s + 4);
        n_total++;
        if (k !== s) $display("FAIL rstmid_restart_read: got %0d expected %0d", k, s);
        else n_pass++;
        if (k < 0) k = s;

        n_total++;
        if (got_frame(k) !== exp_frame(8'h81))
            $display("FAIL rstmid_restart_frame: got %h expected %h", got_frame(k), exp_frame(8'h81));
        else n_pass++;
    endtask

    initial begin
        fif.fifo_empty = 1'b1;
        fif.fifo_data  = 8'h00;
        test_reset();
        test_frame(8'hA5);
        test_frame(8'h01);
        test_back_to_back();
        test_tx_en_drop();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter width, default 8, data bits per frame; matches FIFO width.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range >= 2.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low (0 = reset asserted).
REQ-005 tx_en  input  1  1 = may start new frames; 0 = finish current frame, then hold idle.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_read  output  1  read strobe to FIFO, one cycle per frame.
REQ-008 fifo_data  input  width  FIFO data_out, valid the cycle after the fifo_read edge.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  1 whenever state != IDLE.

Function
REQ-011 FSM states: IDLE, LOAD, START, DATA, PARITY (macro only), STOP.
- IDLE: tx=1; fifo_read = tx_en & !fifo_empty (combinational); next state LOAD when fifo_read=1, else stay.
- LOAD: fifo_read=0; on the edge, latch fifo_data into shift register, clear bit counter and baud counter; next START.
- START: tx=0 for CLKS_PER_BIT cycles; next DATA.
- DATA: tx = shift[0], LSB first; each bit held CLKS_PER_BIT cycles; shift right at bit end; after width bits, next PARITY if compiled in, else STOP.
- PARITY: tx = even parity bit for CLKS_PER_BIT cycles; next STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles; next IDLE.
REQ-012 Baud counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit ends when counter = CLKS_PER_BIT-1; counter then wraps to 0.
REQ-013 Bit counter: 0..width-1, width $clog2(width)+1; no overflow past width.
REQ-014 tx shall be a registered output; no glitches between bits.
REQ-015 Exactly one fifo_read pulse per frame; never asserted while fifo_empty=1 or outside IDLE.
REQ-016 Frame length: (2+width)*CLKS_PER_BIT cycles, +CLKS_PER_BIT with parity; back-to-back frames separated by exactly 2 idle-high cycles (IDLE+LOAD).
REQ-017 tx_en deassert mid-frame: current frame completes unchanged; no new fifo_read until tx_en=1.
REQ-018 fifo_empty rising mid-frame: no effect on current frame.
REQ-019 fifo_data is sampled only in LOAD; changes in other states ignored.

Reset
REQ-020 reset=0 asynchronously forces state IDLE, tx=1, busy=0, fifo_read=0, counters and shift register 0.
REQ-021 Reset mid-frame aborts the frame immediately (tx returns high); byte is lost, no re-read.
REQ-022 After reset release, first fifo_read no earlier than the first posedge with reset=1.

Configuration
REQ-023 Macro FIFO_UART_TX_PARITY_EN: defined -> PARITY state compiled in, even parity (XOR of data bits) sent after last data bit; undefined -> PARITY state and logic absent, STOP follows DATA.

Verification (CLKS_PER_BIT=4, width=8)
REQ-024 Reset held, fifo_empty=0 -> tx=1, fifo_read=0, busy=0 throughout.
REQ-025 One byte 0xA5, tx_en=1 -> one fifo_read pulse; tx = 0(4 cyc),1,0,1,0,0,1,0,1 (4 cyc each),1(4 cyc); 40 cycles; 44 with parity (parity bit 0).
REQ-026 Byte 0x01 with FIFO_UART_TX_PARITY_EN -> parity bit 1; without -> stop immediately after bit 7.
REQ-027 Two bytes 0x55,0x0F queued -> two fifo_read pulses exactly 42 cycles apart; 2-cycle idle-high gap between frames.
REQ-028 tx_en dropped during DATA of 0x3C -> frame completes; fifo_read stays 0 while fifo_empty=0 and tx_en=0; resumes within 1 cycle of tx_en=1.
REQ-029 reset asserted at cycle 10 of a frame -> tx=1 and busy=0 without a clock edge; no fifo_read until after release.
